// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the fetch/load-store requesters, the
// arbiter and a registered-read RAM.
`default_nettype none

interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [7:0]  if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [7:0]  ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [7:0]  ls_rdata;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_load;
    logic        mem_assert;
    logic [7:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_addr, mem_wdata, mem_load, mem_assert
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_addr, mem_wdata, mem_load, mem_assert
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: two-port (fetch / load-store) arbiter onto a single-port RAM
// with load-store priority bounded by a fetch starvation limit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] c_STARVE_LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_streak;
    logic [15:0] r_last_addr;

    logic        w_if_gnt;
    logic        w_ls_gnt;
    logic [15:0] w_mem_addr;

    // Grants are masked by reset so nothing reaches the RAM while rst_n is low.
    assign w_if_gnt = rst_n & bus.if_req & (~bus.ls_req | (r_streak == c_STARVE_LIMIT));
    assign w_ls_gnt = rst_n & bus.ls_req & ~w_if_gnt;

    assign w_mem_addr = w_if_gnt ? bus.if_addr :
                        w_ls_gnt ? bus.ls_addr : r_last_addr;

    assign bus.if_gnt     = w_if_gnt;
    assign bus.ls_gnt     = w_ls_gnt;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_ls_gnt ? bus.ls_wdata : 8'h00;
    assign bus.mem_load   = w_ls_gnt & bus.ls_we;
    assign bus.mem_assert = 1'b0;

    assign bus.if_rvalid = (r_state == ST_IF_RD);
    assign bus.ls_rvalid = (r_state == ST_LS_RD);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_NONE;
            r_streak    <= 3'd0;
            r_last_addr <= 16'h0000;
        end else begin
            if (w_if_gnt) begin
                r_state <= ST_IF_RD;
            end else if (w_ls_gnt && bus.ls_we) begin
                r_state <= ST_LS_WR;
            end else if (w_ls_gnt) begin
                r_state <= ST_LS_RD;
            end else begin
                r_state <= ST_NONE;
            end

            r_last_addr <= w_mem_addr;

            // Streak only counts load/store wins that actually held off a fetch.
            if (!bus.if_req || w_if_gnt) begin
                r_streak <= 3'd0;
            end else if (w_ls_gnt && (r_streak != c_STARVE_LIMIT)) begin
                r_streak <= r_streak + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire
